// File: rtl/gate_vector_checker.sv
// Stimulus/response checker for a 2-input AND/OR/XOR gate block: walks all four (a,b) vectors,
// compares the sampled gate outputs to golden values and reports a pass/fail verdict.
// Optional build macro: GATE_CHK_STOP_ON_FAIL_EN ends a run at the first mismatching vector.
module gate_vector_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             drv_a,
  output logic             drv_b,
  input  logic             smp_and,
  input  logic             smp_or,
  input  logic             smp_xor,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       fail_mask
);

  localparam int unsigned WaitW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned LoopW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [WaitW-1:0] WaitLoad = WaitW'(SETTLE_CYCLES - 1);
  localparam logic [LoopW-1:0] LoopLast = LoopW'(LOOPS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StWait,
    StCheck,
    StDone
  } state_e;

  state_e           state;
  logic [1:0]       vec;
  logic [LoopW-1:0] loop_cnt;
  logic [WaitW-1:0] wait_cnt;

  logic             mismatch;
  logic             last_vec;
  logic             stop_early;
  logic [CNT_W-1:0] err_next;

  // Golden values are derived from the registered drive, which is stable in CHECK.
  always_comb begin
    mismatch = (smp_and != (drv_a & drv_b)) ||
               (smp_or  != (drv_a | drv_b)) ||
               (smp_xor != (drv_a ^ drv_b));
    last_vec = (vec == 2'd3) && (loop_cnt == LoopLast);
    err_next = err_count;
    if (mismatch && !(&err_count)) begin
      err_next = err_count + 1'b1;
    end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    stop_early = mismatch;
`else
    stop_early = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      drv_a     <= 1'b0;
      drv_b     <= 1'b0;
      err_count <= '0;
      fail_mask <= 4'b0000;
      vec       <= 2'd0;
      loop_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state     <= StApply;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= 4'b0000;
            vec       <= 2'd0;
            loop_cnt  <= '0;
          end
        end
        StApply: begin
          drv_a    <= vec[1];
          drv_b    <= vec[0];
          wait_cnt <= WaitLoad;
          state    <= StWait;
        end
        StWait: begin
          if (wait_cnt == '0) begin
            state <= StCheck;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        StCheck: begin
          err_count <= err_next;
          if (mismatch) begin
            fail_mask[vec] <= 1'b1;
          end
          if (last_vec || stop_early) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
            // err_count saturates rather than wraps, so zero really means no mismatch.
            pass  <= !mismatch && (err_count == '0);
            drv_a <= 1'b0;
            drv_b <= 1'b0;
          end else begin
            vec   <= vec + 2'd1;
            state <= StApply;
            if (vec == 2'd3) begin
              loop_cnt <= loop_cnt + 1'b1;
            end
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Scoreboard bench: three checker instances with differing parameters drive faultable gate models.
module tb_gate_vector_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [2:0] busy, done, pass, drv_a, drv_b, s_and, s_or, s_xor;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic [3:0] mask0, mask1, mask2;
  int         mode [3];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string tag;
    int    errs;
    int    mask;
    int    pass;
    int    lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Fault modes: 0 good, 1 xor stuck 0, 2 and stuck 1, 3 all inverted, 4 or stuck 0.
  function automatic logic [2:0] gate(input int m, input logic a, input logic b);
    logic [2:0] g;
    g = {a & b, a | b, a ^ b};
    case (m)
      1:       g[0] = 1'b0;
      2:       g[2] = 1'b1;
      3:       g = ~g;
      4:       g[1] = 1'b0;
      default: ;
    endcase
    return g;
  endfunction

  assign {s_and[0], s_or[0], s_xor[0]} = gate(mode[0], drv_a[0], drv_b[0]);
  assign {s_and[1], s_or[1], s_xor[1]} = gate(mode[1], drv_a[1], drv_b[1]);
  assign {s_and[2], s_or[2], s_xor[2]} = gate(mode[2], drv_a[2], drv_b[2]);

  gate_vector_checker u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .drv_a(drv_a[0]), .drv_b(drv_b[0]), .smp_and(s_and[0]), .smp_or(s_or[0]),
    .smp_xor(s_xor[0]), .err_count(err0), .fail_mask(mask0)
  );

  gate_vector_checker #(.SETTLE_CYCLES(2), .LOOPS(3), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .drv_a(drv_a[1]), .drv_b(drv_b[1]), .smp_and(s_and[1]), .smp_or(s_or[1]),
    .smp_xor(s_xor[1]), .err_count(err1), .fail_mask(mask1)
  );

  gate_vector_checker #(.SETTLE_CYCLES(1), .LOOPS(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .drv_a(drv_a[2]), .drv_b(drv_b[2]), .smp_and(s_and[2]), .smp_or(s_or[2]),
    .smp_xor(s_xor[2]), .err_count(err2), .fail_mask(mask2)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int get_err(input int sel);
    case (sel)
      0:       return int'(err0);
      1:       return int'(err1);
      default: return int'(err2);
    endcase
  endfunction

  function automatic int get_mask(input int sel);
    case (sel)
      0:       return int'(mask0);
      1:       return int'(mask1);
      default: return int'(mask2);
    endcase
  endfunction

  function automatic exp_t model(input string tag, input int m, input int loops,
                                 input int settle, input int cntw);
    exp_t       e;
    int         n;
    bit         stopped;
    logic       a, b;
    logic [2:0] ideal;
    e.tag   = tag;
    e.errs  = 0;
    e.mask  = 0;
    n       = 0;
    stopped = 0;
    for (int l = 0; l < loops; l++) begin
      for (int v = 0; v < 4; v++) begin
        if (!stopped) begin
          n++;
          a     = logic'((v >> 1) & 1);
          b     = logic'(v & 1);
          ideal = {a & b, a | b, a ^ b};
          if (gate(m, a, b) != ideal) begin
            if (e.errs < (1 << cntw) - 1) e.errs++;
            e.mask |= (1 << v);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
            stopped = 1;
`endif
          end
        end
      end
    end
    e.pass = (e.mask == 0) ? 1 : 0;
    e.lat  = n * (settle + 2) + 1;
    return e;
  endfunction

  // Counts negedges after the start edge until done; cyc is the cycle done was seen.
  task automatic wait_done(input int sel, input string tag, output int cyc);
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done[sel]) break;
    end
    check_eq({tag, " done_seen"}, int'(done[sel]), 1);
  endtask

  task automatic run(input int sel, input string tag, input int m, input int loops,
                     input int settle, input int cntw, input bit poke);
    exp_t e;
    int   cyc;
    mode[sel] = m;
    sb.push_back(model(tag, m, loops, settle, cntw));
    @(negedge clk);
    start[sel] = 1'b1;
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      start[sel] = (poke && cyc == 3) ? 1'b1 : 1'b0;
      if (cyc == 1) check_eq({tag, " busy"}, int'(busy[sel]), 1);
      if (done[sel]) break;
    end
    check_eq({tag, " done_seen"}, int'(done[sel]), 1);
    e = sb.pop_front();
    check_eq({e.tag, " latency"}, cyc, e.lat);
    check_eq({e.tag, " pass"}, int'(pass[sel]), e.pass);
    check_eq({e.tag, " err_count"}, get_err(sel), e.errs);
    check_eq({e.tag, " fail_mask"}, get_mask(sel), e.mask);
    check_eq({e.tag, " busy_at_done"}, int'(busy[sel]), 0);
    @(negedge clk);
    check_eq({e.tag, " done_pulse"}, int'(done[sel]), 0);
    @(negedge clk);
    check_eq({e.tag, " no_requeue"}, int'(busy[sel]), 0);
  endtask

  initial begin
    int cyc;
    mode[0] = 0;
    mode[1] = 0;
    mode[2] = 0;
    start   = 3'b000;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset busy", int'(busy), 0);
    check_eq("reset done", int'(done), 0);
    check_eq("reset pass", int'(pass), 0);
    check_eq("reset drv", int'({drv_a, drv_b}), 0);
    check_eq("reset err", int'(err0), 0);
    check_eq("reset mask", int'(mask0), 0);
    rst = 1'b0;

    run(0, "good", 0, 1, 2, 8, 1'b0);
    run(0, "xor0", 1, 1, 2, 8, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("hold err", int'(err0), 2);
    check_eq("hold mask", int'(mask0), 4'b0110);
    check_eq("hold drv", int'({drv_a[0], drv_b[0]}), 0);
    run(1, "loops3_and1", 2, 3, 2, 8, 1'b0);
    run(2, "sat_invert", 3, 2, 1, 2, 1'b0);
    run(0, "or0_poke", 4, 1, 2, 8, 1'b1);

    // Reset in cycle 5 of a run with an already non-zero error count.
    mode[0] = 3;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst err", int'(err0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst busy", int'(busy[0]), 0);
    check_eq("rst drv", int'({drv_a[0], drv_b[0]}), 0);
    check_eq("rst err", int'(err0), 0);
    check_eq("rst mask", int'(mask0), 0);
    run(0, "after_rst", 0, 1, 2, 8, 1'b0);

    // Start held high: back-to-back runs with a single idle cycle between them.
    mode[0] = 0;
    @(negedge clk);
    start[0] = 1'b1;
    wait_done(0, "b2b first", cyc);
    check_eq("b2b first latency", cyc, 17);
    @(negedge clk);
    check_eq("b2b idle busy", int'(busy[0]), 0);
    @(negedge clk);
    check_eq("b2b rearm busy", int'(busy[0]), 1);
    start[0] = 1'b0;
    wait_done(0, "b2b second", cyc);
    check_eq("b2b second latency", cyc, 16);
    check_eq("b2b second pass", int'(pass[0]), 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
